// File: rtl/uart_transmitter_if.sv
// Byte handshake between the producer (FIFO/controller) and the UART transmitter.
// A byte moves on any rising edge where valid and ready are both high.
interface uart_transmitter_if;
  logic [7:0] tx_data;
  logic       valid;
  logic       ready;

  modport master (
    output tx_data,
    output valid,
    input  ready
  );

  modport slave (
    input  tx_data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one handshaked byte per frame as 8N1, each bit held OVERSAMPLE clocks.
// Define UART_TX_PARITY_EN to append an even-parity bit after D7 (8E1).
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | line high, ready for a byte
// S_START  | start bit (line low)
// S_DATA   | data bits D0..D7, LSB first
// S_PARITY | even parity of the byte (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (line high)
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic              uart_samplig_clk,
  input  logic              reset,
  uart_transmitter_if.slave tx_if,
  output logic              busy,
  output logic              RsTx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic handshake;
  logic bit_end;

  assign handshake = tx_if.valid && tx_if.ready;
  assign bit_end   = (cnt_q == CNT_LAST);

  always_ff @(posedge uart_samplig_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // The line value for the next bit is loaded on the edge that ends the
  // current bit, so RsTx comes straight from a flop with no decode glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (handshake) begin
          shift_d = tx_if.tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_if.tx_data;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_if.ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign RsTx        = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of bytes checked bit-by-bit on the line,
// plus hand-written idle, back-to-back, data-change and mid-frame reset sequences.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic rstx;

  uart_transmitter_if tx_if();

  uart_transmitter #(.OVERSAMPLE(OS)) dut (
    .uart_samplig_clk(clk),
    .reset           (rst),
    .tx_if           (tx_if),
    .busy            (busy),
    .RsTx            (rstx)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         hold;
    bit         chg;
    logic [7:0] chg_val;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input vec_t v);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, v.par, v.data, 1'b0};
`else
    f = {2'b01, v.data, 1'b0};
`endif
    return f;
  endfunction

  // Called right after the handshake edge T; first negedge is within cycle T+1.
  task automatic check_frame(input string tag, input logic [10:0] frame);
    logic rdy_seen;
    logic busy_drop;
    int   b;
    int   ph;
    rdy_seen  = 1'b0;
    busy_drop = 1'b0;
    for (int c = 0; c < OS * NB; c++) begin
      @(negedge clk);
      b  = c / OS;
      ph = c % OS;
      if (tx_if.ready) rdy_seen = 1'b1;
      if (!busy) busy_drop = 1'b1;
      if (ph == 0 || ph == OS / 2 || ph == OS - 1)
        check($sformatf("%s bit%0d c%0d", tag, b, c), rstx, frame[b[3:0]]);
    end
    check({tag, " ready_low_in_frame"}, rdy_seen, 1'b0);
    check({tag, " busy_high_in_frame"}, busy_drop, 1'b0);
    @(negedge clk);
    check({tag, " ready_back"}, tx_if.ready, 1'b1);
    check({tag, " busy_back"}, busy, 1'b0);
    check({tag, " line_idle"}, rstx, 1'b1);
  endtask

  // Entered at a negedge; leaves at the negedge after the frame's stop bit.
  task automatic send(input string tag, input vec_t v);
    int w;
    w = 0;
    tx_if.tx_data = v.data;
    tx_if.valid   = 1'b1;
    while (!tx_if.ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_wait"}, tx_if.ready, 1'b1);
    if (!tx_if.ready) begin
      tx_if.valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!v.hold) tx_if.valid = 1'b0;
    if (v.chg) tx_if.tx_data = v.chg_val;
    check_frame(tag, frame_of(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic bad;
    vec_t v81;

    rst           = 1'b1;
    tx_if.valid   = 1'b0;
    tx_if.tx_data = 8'h00;

    vecs[0] = '{data: 8'h55, par: 1'b0, hold: 1'b0, chg: 1'b0, chg_val: 8'h00};
    vecs[1] = '{data: 8'hA3, par: 1'b0, hold: 1'b1, chg: 1'b1, chg_val: 8'h0F};
    vecs[2] = '{data: 8'h0F, par: 1'b0, hold: 1'b0, chg: 1'b0, chg_val: 8'h00};
    vecs[3] = '{data: 8'h00, par: 1'b0, hold: 1'b0, chg: 1'b1, chg_val: 8'hFF};
    vecs[4] = '{data: 8'h07, par: 1'b1, hold: 1'b0, chg: 1'b0, chg_val: 8'h00};
    vecs[5] = '{data: 8'h03, par: 1'b0, hold: 1'b0, chg: 1'b0, chg_val: 8'h00};
    v81     = '{data: 8'h81, par: 1'b0, hold: 1'b0, chg: 1'b0, chg_val: 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset RsTx", rstx, 1'b1);
    check("reset ready", tx_if.ready, 1'b1);
    check("reset busy", busy, 1'b0);
    rst = 1'b0;

    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rstx !== 1'b1 || tx_if.ready !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("idle_500_quiet", bad, 1'b0);

    // Entry 1 holds valid with 0x0F queued, so entry 2 handshakes at T+161.
    for (int i = 0; i < 6; i++)
      send($sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i]);

    tx_if.tx_data = 8'h00;
    tx_if.valid   = 1'b1;
    check("mid_reset ready_pre", tx_if.ready, 1'b1);
    @(posedge clk);
    #1;
    tx_if.valid = 1'b0;
    repeat (69) @(posedge clk);
    #3;
    check("mid_reset line_low_before", rstx, 1'b0);
    check("mid_reset busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_reset RsTx_async", rstx, 1'b1);
    check("mid_reset ready_async", tx_if.ready, 1'b1);
    check("mid_reset busy_async", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("post_reset ready", tx_if.ready, 1'b1);
    check("post_reset RsTx", rstx, 1'b1);
    send("after_reset_81", v81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
